// File: rtl/pipeline_debug_pkg.sv
// rtl/pipeline_debug_pkg.sv - shared encodings for the pipeline debug controller
package pipeline_debug_pkg;

    typedef enum logic [2:0] {
        ST_HALT     = 3'd0,
        ST_RUN      = 3'd1,
        ST_STEP     = 3'd2,
        ST_DUMP_REQ = 3'd3,
        ST_DUMP_TX  = 3'd4
    } dbg_state_t;

    localparam logic [1:0] OP_RUN  = 2'b00;
    localparam logic [1:0] OP_STEP = 2'b01;
    localparam logic [1:0] OP_HALT = 2'b10;
    localparam logic [1:0] OP_DUMP = 2'b11;

    localparam logic [1:0] CAUSE_CMD        = 2'b00;
    localparam logic [1:0] CAUSE_BP         = 2'b01;
    localparam logic [1:0] CAUSE_HALT_INSTR = 2'b10;
    localparam logic [1:0] CAUSE_STEP       = 2'b11;

    localparam int DUMP_WORDS = 34;
    localparam int IDX_W      = 6;

    // Priority when several stop sources fire together: halt_instr, then breakpoint, then command.
    function automatic logic [1:0] stop_cause_of(input logic halt_instr, input logic bp_hit);
        if (halt_instr)
            return CAUSE_HALT_INSTR;
        else if (bp_hit)
            return CAUSE_BP;
        else
            return CAUSE_CMD;
    endfunction

endpackage

// File: rtl/debug_dump_seq.sv
// rtl/debug_dump_seq.sv - dump word index, word source mux and tx handshake
module debug_dump_seq
    import pipeline_debug_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_phase,
    input  logic        tx_phase,
    input  logic [31:0] debug_data,
    input  logic [31:0] pc_if,
    input  logic [31:0] cycle_count,
    input  logic        tx_ready,
    output logic [31:0] debug_address,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    output logic        word_accept,
    output logic        last_word
);

    logic [IDX_W-1:0] index;
    logic [31:0]      word_src;

    // Words 0..31 are register reads; the last two carry the PC and the cycle counter.
    always_comb begin
        word_src = debug_data;
        if (index == IDX_W'(DUMP_WORDS - 2))
            word_src = pc_if;
        else if (index == IDX_W'(DUMP_WORDS - 1))
            word_src = cycle_count;
    end

    assign debug_address = {{(32 - IDX_W){1'b0}}, index};
    assign word_accept   = tx_phase && tx_ready;
    assign last_word     = (index == IDX_W'(DUMP_WORDS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            index    <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else if (req_phase) begin
            tx_data  <= word_src;
            tx_valid <= 1'b1;
        end else if (word_accept) begin
            tx_valid <= 1'b0;
            index    <= last_word ? '0 : index + IDX_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_debug_ctrl.sv
// rtl/pipeline_debug_ctrl.sv - run/step/halt/dump debug controller for a pipelined core
module pipeline_debug_ctrl
    import pipeline_debug_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    output logic        cmd_ready,
    input  logic        bp_enable,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc_if,
    input  logic        halt_instr,
    output logic        pipe_enable,
    output logic        debugMode,
    output logic [31:0] DebugAddress,
    input  logic [31:0] debug_data,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halted,
    output logic [1:0]  stop_cause,
    output logic [31:0] cycle_count
);

    dbg_state_t state;
    logic       bp_skip;
    logic       bp_hit;
    logic       stop;
    logic       cmd_fire;
    logic       word_accept;
    logic       last_word;

    assign cmd_ready   = (state == ST_HALT) || (state == ST_RUN);
    assign cmd_fire    = cmd_valid && cmd_ready;
    // bp_skip masks the breakpoint for one cycle so a resume at the breakpoint PC makes progress.
    assign bp_hit      = bp_enable && (pc_if == bp_addr) && !bp_skip;
    assign stop        = halt_instr || bp_hit || (cmd_valid && cmd_op == OP_HALT);
    assign pipe_enable = ((state == ST_RUN) && !stop) || (state == ST_STEP);
    assign halted      = (state == ST_HALT);
    assign debugMode   = (state == ST_HALT) || (state == ST_DUMP_REQ) || (state == ST_DUMP_TX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_HALT;
            stop_cause  <= CAUSE_CMD;
            cycle_count <= '0;
            bp_skip     <= 1'b0;
        end else begin
            bp_skip <= 1'b0;
            if (pipe_enable && cycle_count != 32'hFFFF_FFFF)
                cycle_count <= cycle_count + 32'd1;
            case (state)
                ST_HALT: begin
                    if (cmd_fire) begin
                        case (cmd_op)
                            OP_RUN: begin
                                state   <= ST_RUN;
                                bp_skip <= 1'b1;
                            end
                            OP_STEP: state <= ST_STEP;
                            OP_DUMP: state <= ST_DUMP_REQ;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state      <= ST_HALT;
                        stop_cause <= stop_cause_of(halt_instr, bp_hit);
                    end
                end
                ST_STEP: begin
                    state      <= ST_HALT;
                    stop_cause <= CAUSE_STEP;
                end
                ST_DUMP_REQ: state <= ST_DUMP_TX;
                ST_DUMP_TX: begin
                    if (word_accept)
                        state <= last_word ? ST_HALT : ST_DUMP_REQ;
                end
                default: state <= ST_HALT;
            endcase
        end
    end

    debug_dump_seq u_dump (
        .clk           (clk),
        .reset         (reset),
        .req_phase     (state == ST_DUMP_REQ),
        .tx_phase      (state == ST_DUMP_TX),
        .debug_data    (debug_data),
        .pc_if         (pc_if),
        .cycle_count   (cycle_count),
        .tx_ready      (tx_ready),
        .debug_address (DebugAddress),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .word_accept   (word_accept),
        .last_word     (last_word)
    );

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// tb/tb_pipeline_debug_ctrl.sv - self-checking bench for pipeline_debug_ctrl
module tb_pipeline_debug_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic        cmd_ready;
    logic        bp_enable;
    logic [31:0] bp_addr;
    logic [31:0] pc_if;
    logic        halt_instr;
    logic        pipe_enable;
    logic        debugMode;
    logic [31:0] DebugAddress;
    logic [31:0] debug_data;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halted;
    logic [1:0]  stop_cause;
    logic [31:0] cycle_count;

    always #5 clk = ~clk;

    assign debug_data = 32'hA000_0000 + DebugAddress;

    pipeline_debug_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .cmd_ready    (cmd_ready),
        .bp_enable    (bp_enable),
        .bp_addr      (bp_addr),
        .pc_if        (pc_if),
        .halt_instr   (halt_instr),
        .pipe_enable  (pipe_enable),
        .debugMode    (debugMode),
        .DebugAddress (DebugAddress),
        .debug_data   (debug_data),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .halted       (halted),
        .stop_cause   (stop_cause),
        .cycle_count  (cycle_count)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Behavioural model: debugger mode, one-shot breakpoint mask, cause, counter, dump progress.
    typedef enum int {M_HALT, M_RUN, M_STEP, M_DUMP} mmode_t;
    mmode_t      m_mode = M_HALT, n_mode = M_HALT;
    bit          m_first = 1'b0, n_first = 1'b0;
    logic [1:0]  m_cause = 2'd0, n_cause = 2'd0;
    longint      m_count = 0, n_count = 0;
    int          m_idx = 0, n_idx = 0;
    bit          m_present = 1'b0, n_present = 1'b0;
    bit          exp_pe = 1'b0;
    logic [31:0] rx_q[$];

    always @(negedge clk) begin
        bit          bp;
        bit          stp;
        bit          pe;
        bit          valid;
        logic [31:0] word;
        bp    = (m_mode == M_RUN) && bp_enable && (pc_if == bp_addr) && !m_first;
        stp   = halt_instr || bp || (cmd_valid && cmd_op == 2'b10);
        pe    = ((m_mode == M_RUN) && !stp) || (m_mode == M_STEP);
        valid = (m_mode == M_DUMP) && m_present;
        word  = (m_idx < 32) ? 32'hA000_0000 + 32'(m_idx)
              : (m_idx == 32) ? pc_if : m_count[31:0];
        exp_pe = pe;
        if (chk_en) begin
            check("pipe_enable", pipe_enable, pe);
            check("halted", halted, m_mode == M_HALT);
            check("debugMode", debugMode, (m_mode == M_HALT) || (m_mode == M_DUMP));
            check("cmd_ready", cmd_ready, (m_mode == M_HALT) || (m_mode == M_RUN));
            check("stop_cause", stop_cause, m_cause);
            check("cycle_count", cycle_count, m_count[31:0]);
            check("tx_valid", tx_valid, valid);
            if (valid)
                check("tx_data", tx_data, word);
            if (m_mode == M_DUMP && !m_present)
                check("DebugAddress", DebugAddress, 32'(m_idx));
            if (tx_valid && tx_ready)
                rx_q.push_back(tx_data);
        end

        n_mode    = m_mode;
        n_first   = 1'b0;
        n_cause   = m_cause;
        n_idx     = m_idx;
        n_present = m_present;
        n_count   = (pe && m_count < 64'hFFFF_FFFF) ? m_count + 1 : m_count;
        if (reset) begin
            n_mode = M_HALT; n_cause = 2'd0; n_count = 0; n_idx = 0; n_present = 1'b0;
        end else begin
            case (m_mode)
                M_HALT: if (cmd_valid) begin
                    if (cmd_op == 2'b00) begin n_mode = M_RUN; n_first = 1'b1; end
                    else if (cmd_op == 2'b01) n_mode = M_STEP;
                    else if (cmd_op == 2'b11) begin n_mode = M_DUMP; n_idx = 0; n_present = 1'b0; end
                end
                M_RUN: if (stp) begin
                    n_mode  = M_HALT;
                    n_cause = halt_instr ? 2'd2 : (bp ? 2'd1 : 2'd0);
                end
                M_STEP: begin n_mode = M_HALT; n_cause = 2'd3; end
                M_DUMP: begin
                    if (!m_present)
                        n_present = 1'b1;
                    else if (tx_ready) begin
                        n_present = 1'b0;
                        if (m_idx == 33) begin n_mode = M_HALT; n_idx = 0; end
                        else n_idx = m_idx + 1;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        m_mode    <= n_mode;
        m_first   <= n_first;
        m_cause   <= n_cause;
        m_count   <= n_count;
        m_idx     <= n_idx;
        m_present <= n_present;
    end

    // The bench plays the fetch stage: PC advances by 4 on every enabled cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (exp_pe) pc_if = pc_if + 32'd4;
    endtask

    task automatic send(input logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_halted(input string name, input int bound);
        for (int i = 0; i < bound && !halted; i++) tick();
        check(name, halted, 1'b1);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; bp_enable = 1'b0; bp_addr = '0;
        pc_if = '0; halt_instr = 1'b0; tx_ready = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        tick();
        check("rst_halted", halted, 1'b1);
        check("rst_debugMode", debugMode, 1'b1);
        check("rst_pipe_enable", pipe_enable, 1'b0);
        check("rst_DebugAddress", DebugAddress, 32'h0);
        check("rst_tx_data", tx_data, 32'h0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_stop_cause", stop_cause, 2'b00);
        check("rst_cycle_count", cycle_count, 32'd0);
        reset = 1'b0;

        // Breakpoint at 0x10 with PC from 0: four enabled cycles, then stop.
        bp_enable = 1'b1; bp_addr = 32'h10;
        send(2'b00);
        wait_halted("bp_stop_halted", 20);
        check("bp_stop_cause", stop_cause, 2'b01);
        check("bp_stop_count", cycle_count, 32'd4);

        // Resume sitting on the breakpoint PC, then halt by command.
        send(2'b00);
        check("resume_pe", pipe_enable, 1'b1);
        tick(); tick(); tick();
        send(2'b10);
        check("cmd_halt_halted", halted, 1'b1);
        check("cmd_halt_cause", stop_cause, 2'b00);
        check("cmd_halt_count", cycle_count, 32'd7);

        // Single step.
        send(2'b01);
        check("step_pe", pipe_enable, 1'b1);
        tick();
        check("step_halted", halted, 1'b1);
        check("step_cause", stop_cause, 2'b11);
        check("step_count", cycle_count, 32'd8);

        // halt_instr coinciding with a breakpoint hit.
        bp_addr = pc_if + 32'd8;
        send(2'b00);
        for (int i = 0; i < 20 && !halted; i++) begin
            halt_instr = (pc_if == bp_addr);
            tick();
        end
        halt_instr = 1'b0;
        check("coincide_halted", halted, 1'b1);
        check("coincide_cause", stop_cause, 2'b10);
        check("coincide_count", cycle_count, 32'd10);

        // Dump with tx_ready toggling.
        rx_q.delete();
        send(2'b11);
        for (int i = 0; i < 300 && !halted; i++) begin
            tx_ready = ~tx_ready;
            tick();
        end
        tx_ready = 1'b0;
        check("dump_halted", halted, 1'b1);
        check("dump_words", 32'(rx_q.size()), 32'd34);
        if (rx_q.size() == 34) begin
            check("dump_w0", rx_q[0], 32'hA000_0000);
            check("dump_w31", rx_q[31], 32'hA000_001F);
            check("dump_w32", rx_q[32], 32'h28);
            check("dump_w33", rx_q[33], 32'd10);
        end

        // Reset in the middle of a dump, then a fresh dump from word 0.
        rx_q.delete();
        tx_ready = 1'b1;
        send(2'b11);
        for (int i = 0; i < 100 && rx_q.size() < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_tx_valid", tx_valid, 1'b0);
        check("mid_rst_halted", halted, 1'b1);
        rx_q.delete();
        send(2'b11);
        wait_halted("redump_halted", 200);
        check("redump_words", 32'(rx_q.size()), 32'd34);
        if (rx_q.size() == 34) begin
            check("redump_w0", rx_q[0], 32'hA000_0000);
            check("redump_w33", rx_q[33], 32'd0);
        end
        tx_ready = 1'b0;

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            cmd_valid  = ($urandom_range(0, 3) == 0);
            cmd_op     = 2'($urandom_range(0, 3));
            bp_enable  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)
                bp_addr = pc_if + 32'(4 * $urandom_range(0, 3));
            halt_instr = ($urandom_range(0, 15) == 0);
            tx_ready   = 1'($urandom_range(0, 1));
            reset      = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset = 1'b0; cmd_valid = 1'b0; halt_instr = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
